// File: rtl/esm_retire_buffer.sv
// Program-order retirement buffer: accepts out-of-order issues tagged with their
// dispatch sequence number and releases them strictly in tag order, one per cycle.
module esm_retire_buffer #(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16,
  parameter int TAG_W                 = $clog2(bs)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             issue_valid,
  input  logic [Instruction_word_size-1:0] issue_instr,
  input  logic [TAG_W-1:0]                 issue_tag,
  input  logic                             issue_regwrite,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             retire_valid,
  output logic [TAG_W-1:0]                 retire_tag,
  output logic                             retire_regwrite,
  output logic [TAG_W:0]                   pending,
  output logic                             err_collision
);

  localparam int W = Instruction_word_size;

  logic [bs-1:0]    valid_q, valid_d;
  logic [W-1:0]     instr_q [bs];
  logic [bs-1:0]    rw_q;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W:0]   pending_q, pending_d;
  logic             err_q, err_d;
  logic [W-1:0]     out_instr_q, out_instr_d;
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_rw_q, out_rw_d;

  logic retire;
  logic slot_hit;
  logic accept;
  logic write_en;

  // A retiring head slot still counts as occupied, so an issue to it collides.
  assign retire   = valid_q[head_q];
  assign slot_hit = valid_q[issue_tag];
  assign accept   = issue_valid && !slot_hit;
  assign write_en = !flush && accept;

  always_comb begin
    valid_d     = valid_q;
    head_d      = head_q;
    pending_d   = pending_q;
    err_d       = err_q;
    out_instr_d = '0;
    out_valid_d = 1'b0;
    out_tag_d   = '0;
    out_rw_d    = 1'b0;

    if (flush) begin
      valid_d   = '0;
      head_d    = '0;
      pending_d = '0;
      err_d     = 1'b0;
    end else begin
      if (accept) begin
        valid_d[issue_tag] = 1'b1;
      end
      if (issue_valid && slot_hit) begin
        err_d = 1'b1;
      end
      if (retire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
        out_instr_d     = instr_q[head_q];
        out_valid_d     = 1'b1;
        out_tag_d       = head_q;
        out_rw_d        = rw_q[head_q];
      end
      if (accept && !retire) begin
        pending_d = pending_q + (TAG_W+1)'(1);
      end else if (!accept && retire) begin
        pending_d = pending_q - (TAG_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      head_q      <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_rw_q    <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      head_q      <= head_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_rw_q    <= out_rw_d;
    end
  end

  // Payload storage needs no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (write_en) begin
      instr_q[issue_tag] <= issue_instr;
      rw_q[issue_tag]    <= issue_regwrite;
    end
  end

  assign Instr_out       = out_instr_q;
  assign retire_valid    = out_valid_q;
  assign retire_tag      = out_tag_q;
  assign retire_regwrite = out_rw_q;
  assign pending         = pending_q;
  assign err_collision   = err_q;

endmodule

// File: tb/tb_esm_retire_buffer.sv
// Directed bench for esm_retire_buffer: reset, in-order, reorder, wrap, full/collision, flush.
module tb_esm_retire_buffer;

  localparam int W     = 32;
  localparam int BS    = 16;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             issue_valid;
  logic [W-1:0]     issue_instr;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_regwrite;
  logic [W-1:0]     Instr_out;
  logic             retire_valid;
  logic [TAG_W-1:0] retire_tag;
  logic             retire_regwrite;
  logic [TAG_W:0]   pending;
  logic             err_collision;

  int n_cmp;
  int n_err;

  esm_retire_buffer #(
    .Instruction_word_size(W),
    .bs(BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .issue_valid(issue_valid),
    .issue_instr(issue_instr),
    .issue_tag(issue_tag),
    .issue_regwrite(issue_regwrite),
    .Instr_out(Instr_out),
    .retire_valid(retire_valid),
    .retire_tag(retire_tag),
    .retire_regwrite(retire_regwrite),
    .pending(pending),
    .err_collision(err_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [TAG_W-1:0] t, input logic [W-1:0] ins, input logic rw);
    issue_valid    = 1'b1;
    issue_tag      = t;
    issue_instr    = ins;
    issue_regwrite = rw;
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    issue_tag      = '0;
    issue_instr    = '0;
    issue_regwrite = 1'b0;
  endtask

  task automatic expect_retire(input string tag, input logic [TAG_W-1:0] t,
                               input logic [W-1:0] ins, input logic rw, input int pend);
    chk({tag, "_valid"}, 32'(retire_valid), 32'd1);
    chk({tag, "_instr"}, Instr_out, ins);
    chk({tag, "_tag"}, 32'(retire_tag), 32'(t));
    chk({tag, "_rw"}, 32'(retire_regwrite), 32'(rw));
    chk({tag, "_pend"}, 32'(pending), 32'(pend));
  endtask

  task automatic expect_gap(input string tag, input int pend);
    chk({tag, "_valid"}, 32'(retire_valid), 32'd0);
    chk({tag, "_instr"}, Instr_out, 32'd0);
    chk({tag, "_rw"}, 32'(retire_regwrite), 32'd0);
    chk({tag, "_pend"}, 32'(pending), 32'(pend));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    flush = 1'b0;
    issue(4'd0, 32'hDEADBEEF, 1'b1);

    // Reset held with issue active
    tick();
    tick();
    chk("rst_instr", Instr_out, 32'd0);
    chk("rst_valid", 32'(retire_valid), 32'd0);
    chk("rst_tag", 32'(retire_tag), 32'd0);
    chk("rst_rw", 32'(retire_regwrite), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_err", 32'(err_collision), 32'd0);
    rst = 1'b1;
    idle();
    tick();
    expect_gap("post_rst", 0);

    // Reorder: tags 1, 2, 0
    issue(4'd1, 32'h01400113, 1'b1);
    tick();
    expect_gap("ro_a", 1);
    issue(4'd2, 32'h002081B3, 1'b0);
    tick();
    expect_gap("ro_b", 2);
    issue(4'd0, 32'h00A00093, 1'b1);
    tick();
    expect_gap("ro_c", 3);
    idle();
    tick();
    expect_retire("ro_r0", 4'd0, 32'h00A00093, 1'b1, 2);
    tick();
    expect_retire("ro_r1", 4'd1, 32'h01400113, 1'b1, 1);
    tick();
    expect_retire("ro_r2", 4'd2, 32'h002081B3, 1'b0, 0);
    tick();
    expect_gap("ro_end", 0);

    // In-order stream after returning head to 0
    do_flush();
    expect_gap("fl0", 0);
    issue(4'd0, 32'h00A00093, 1'b1);
    tick();
    expect_gap("io_a", 1);
    issue(4'd1, 32'h01400113, 1'b1);
    tick();
    expect_retire("io_r0", 4'd0, 32'h00A00093, 1'b1, 1);
    issue(4'd2, 32'h002081B3, 1'b0);
    tick();
    expect_retire("io_r1", 4'd1, 32'h01400113, 1'b1, 1);
    idle();
    tick();
    expect_retire("io_r2", 4'd2, 32'h002081B3, 1'b0, 0);
    tick();
    expect_gap("io_end", 0);

    // Wrap-around: 20 in-order issues, tags 0..15,0..3
    do_flush();
    for (int i = 0; i < 20; i++) begin
      issue(4'(i), 32'h10000000 + 32'(i), 1'(i));
      tick();
      if (i == 0) expect_gap("wr_first", 1);
      else expect_retire("wr", 4'(i - 1), 32'h10000000 + 32'(i - 1), 1'(i - 1), 1);
    end
    idle();
    tick();
    expect_retire("wr_last", 4'd3, 32'h10000013, 1'b1, 0);
    chk("wr_err", 32'(err_collision), 32'd0);
    tick();
    expect_gap("wr_end", 0);

    // Full and collision: withhold tag 0, then collide on tag 1
    do_flush();
    for (int t = 1; t < 16; t++) begin
      issue(4'(t), 32'h20000000 + 32'(t), 1'(t));
      tick();
      chk("fu_err_clear", 32'(err_collision), 32'd0);
    end
    issue(4'd1, 32'hBADBAD01, 1'b0);
    tick();
    expect_gap("fu_coll", 15);
    chk("fu_err_set", 32'(err_collision), 32'd1);
    issue(4'd0, 32'h20000000, 1'b0);
    tick();
    expect_gap("fu_full", 16);
    idle();
    for (int k = 0; k < 16; k++) begin
      tick();
      expect_retire("fu", 4'(k), 32'h20000000 + 32'(k), 1'(k), 15 - k);
    end
    chk("fu_err_sticky", 32'(err_collision), 32'd1);

    // Flush with pending=5, err=1, issue active during flush
    for (int t = 1; t < 6; t++) begin
      issue(4'(t), 32'h30000000 + 32'(t), 1'b1);
      tick();
    end
    idle();
    tick();
    expect_gap("pf", 5);
    chk("pf_err", 32'(err_collision), 32'd1);
    issue(4'd0, 32'hCAFEF00D, 1'b1);
    do_flush();
    expect_gap("fl", 0);
    chk("fl_err", 32'(err_collision), 32'd0);
    idle();
    tick();
    expect_gap("fl_ignored", 0);
    issue(4'd0, 32'h00A00093, 1'b1);
    tick();
    expect_gap("fl_iss", 1);
    chk("fl_iss_err", 32'(err_collision), 32'd0);
    idle();
    tick();
    expect_retire("fl_ret", 4'd0, 32'h00A00093, 1'b1, 0);

    // Asynchronous reset mid-stream
    issue(4'd1, 32'h44444444, 1'b1);
    tick();
    idle();
    tick();
    expect_retire("ar_pre", 4'd1, 32'h44444444, 1'b1, 0);
    issue(4'd2, 32'h55555555, 1'b1);
    tick();
    chk("ar_pend", 32'(pending), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    expect_gap("ar", 0);
    chk("ar_err", 32'(err_collision), 32'd0);
    idle();
    tick();
    rst = 1'b1;
    tick();
    tick();
    expect_gap("ar_dropped", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/esm_retire_buffer.md
# esm_retire_buffer

Program-order retirement buffer on the consumer side of the ESM scheduler. The ESM issues instructions on `Instr_out` in an order of its own choosing. This block accepts each issued instruction tagged with its dispatch sequence number, holds it in a `bs`-entry slot array, and releases instructions strictly in dispatch order, one per cycle. It sits between the ESM output and the register-file writeback / trace logic.

## Interface
- `Instruction_word_size`, 32, instruction width in bits.
- `bs`, 16, slot count; must be a power of two and ≥2; must equal the ESM `bs`.
- `TAG_W`, $clog2(bs), sequence-tag width (derived; do not override).

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `flush`  in  1  synchronous clear of all slots and pointers; priority over all other inputs.
- `issue_valid`  in  1  issue strobe from the ESM side; an instruction is present this cycle.
- `issue_instr`  in  Instruction_word_size  issued instruction word.
- `issue_tag`  in  TAG_W  dispatch sequence number modulo bs.
- `issue_regwrite`  in  1  RegWrite travelling with the instruction.
- `Instr_out`  out  Instruction_word_size  retired instruction; 32'h0 (NOP) when nothing retires.
- `retire_valid`  out  1  retirement strobe; high for one cycle per retired instruction.
- `retire_tag`  out  TAG_W  tag of the retired instruction.
- `retire_regwrite`  out  1  RegWrite of the retired instruction; 0 when `retire_valid` = 0.
- `pending`  out  TAG_W+1  number of occupied slots (0..bs).
- `err_collision`  out  1  sticky; set when an issue targets an already-occupied slot.

## Operation
- Storage: per slot, a valid bit, the instruction word, and the RegWrite bit. Slots are indexed directly by `issue_tag`.
- Head pointer `head` (TAG_W bits) holds the next tag expected to retire. It starts at 0 and wraps from bs−1 to 0 by natural overflow.
- Issue: when `issue_valid` = 1 and slot[`issue_tag`] is empty, the block writes the instruction and RegWrite and sets the slot's valid bit.
- Collision: when `issue_valid` = 1 and slot[`issue_tag`] is already valid, the write is dropped, the stored entry is untouched, and `err_collision` is set. The flag clears only on reset or flush.
- Retire: each cycle, if slot[`head`] is valid, the block:
  - registers its contents onto `Instr_out`, `retire_tag` = `head`, `retire_regwrite`, and `retire_valid` = 1;
  - clears slot[`head`];
  - increments `head`.
- If slot[`head`] is empty, the outputs for the next cycle are `Instr_out` = 0, `retire_valid` = 0, and `retire_regwrite` = 0. This is a gap: `head` does not advance, and later occupied slots wait.
- The block makes at most one retirement per cycle.
- Simultaneous issue and retire on different slots: both take effect in the same cycle.
- Issue into slot[`head`] while it is empty: the instruction is written this edge and retires on the next edge. There is no same-cycle bypass.
- Issue into slot[`head`] while it is occupied and retiring this cycle: this counts as a collision. The slot is still occupied at the time of the write, so the write is dropped and the old entry retires.
- `pending` = the number of valid bits after the edge. It is updated as +1 for an accepted issue and −1 for a retire, and stays unchanged when both happen or neither happens.
- Flush: the block clears all valid bits, sets `head` = 0, `pending` = 0, and `err_collision` = 0, and drives all retire outputs to 0 at the next edge. `issue_valid` is ignored during the flush cycle.

## Timing
- Reset (`rst` = 0): takes effect asynchronously. Every output is 0:
  - `Instr_out` = 0, `retire_valid` = 0, `retire_tag` = 0, `retire_regwrite` = 0, `pending` = 0, `err_collision` = 0;
  - all valid bits are cleared and `head` = 0.
- Reset deassertion is synchronous to `clk` at the first rising edge. Reset asserted mid-stream discards all held instructions.
- Latency:
  - The minimum from issue to `retire_valid` is 1 cycle (issue at edge N, outputs visible after edge N+1).
  - An out-of-order instruction retires 1 cycle after its last predecessor retires.
- Throughput: one issue and one retire per cycle, sustained.
- All outputs are registered; no combinational path runs from inputs to outputs.
- Full condition: `pending` = bs. Every slot is occupied, so any further issue is a collision.

## Test plan
- Reset sanity: hold `rst` = 0 for 2 cycles with `issue_valid` = 1 → all outputs 0; after release, `pending` = 0 and `Instr_out` = 0.
- In-order stream: issue tags 0,1,2 with 32'h00A00093, 32'h01400113, 32'h002081B3 on consecutive cycles → `retire_valid` high for 3 cycles starting 1 cycle after the first issue, with `Instr_out` in the same order and `retire_tag` 0,1,2.
- Reorder: issue tag 1 (32'h01400113), then tag 2 (32'h002081B3), then tag 0 (32'h00A00093) → no retirement until the cycle after tag 0 is issued, then 00A00093, 01400113, 002081B3 on three consecutive cycles; `pending` goes 1,2,3,2,1,0.
- Wrap-around: stream 20 in-order issues with tags 0..15,0..3 → 20 consecutive retirements, `retire_tag` wraps 15→0, `err_collision` stays 0.
- Full and collision: issue 16 tags while withholding tag 0 (send tags 1..15, then tag 1 again) → `pending` = 15 and `err_collision` = 1, with the original tag-1 word preserved. Then issue tag 0 → 16 retirements in order.
- Flush: with `pending` = 5 and `err_collision` = 1, pulse `flush` for 1 cycle with `issue_valid` = 1 → `pending` = 0, `err_collision` = 0, no retirement; a subsequent tag-0 issue retires 1 cycle later.
